// File: rtl/pcfetch.sv
// pcfetch: instruction fetch front end.
// Issues one instruction-bus request at a time, presents the returned word
// to decode, and handles redirects from execute by discarding any response
// that belongs to a superseded program counter.
// Optional feature macro: PCFETCH_MISALIGN_EN. When defined, a PC that is not
// 4-byte aligned is reported as a misalignment fault slot instead of being
// requested on the bus. When undefined, out_misalign is always 0.
module pcfetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILL,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] tgt_q, tgt_d;
    logic        outValid_q, outValid_d;
    logic [63:0] outPc_q, outPc_d;
    logic [31:0] outInstr_q, outInstr_d;
    logic        outMisalign_q, outMisalign_d;
    logic        misalignFault;

`ifdef PCFETCH_MISALIGN_EN
    assign misalignFault = (state_q == REQ) && (pc_q[1:0] != 2'b00);
`else
    assign misalignFault = 1'b0;
`endif

    // Next-state, bus request and output-slot update for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        outValid_d    = outValid_q;
        outPc_d       = outPc_q;
        outInstr_d    = outInstr_q;
        outMisalign_d = outMisalign_q;
        ireq_valid    = 1'b0;
        ireq_addr     = pc_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_en) begin
                    pc_d = redirect_pc;
                end
            end

            REQ: begin
                if (misalignFault) begin
                    if (redirect_en) begin
                        pc_d = redirect_pc;
                    end else begin
                        outValid_d    = 1'b1;
                        outPc_d       = pc_q;
                        outInstr_d    = 32'h0;
                        outMisalign_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else begin
                    ireq_valid = 1'b1;
                    if (iresp_data_ok) begin
                        if (redirect_en) begin
                            pc_d = redirect_pc;
                        end else begin
                            outValid_d    = 1'b1;
                            outPc_d       = pc_q;
                            outInstr_d    = iresp_data;
                            outMisalign_d = 1'b0;
                            pc_d          = pc_q + 64'd4;
                            state_d       = HOLD;
                        end
                    end else if (redirect_en) begin
                        tgt_d   = redirect_pc;
                        state_d = KILL;
                    end
                end
            end

            KILL: begin
                ireq_valid = 1'b1;
                if (redirect_en) begin
                    tgt_d = redirect_pc;
                end
                if (iresp_data_ok) begin
                    pc_d    = redirect_en ? redirect_pc : tgt_q;
                    state_d = REQ;
                end
            end

            HOLD: begin
                if (redirect_en) begin
                    outValid_d    = 1'b0;
                    outMisalign_d = 1'b0;
                    pc_d          = redirect_pc;
                    state_d       = REQ;
                end else if (!stall) begin
                    outValid_d    = 1'b0;
                    outMisalign_d = 1'b0;
                    state_d       = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, redirect target and presented slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            tgt_q         <= 64'h0;
            outValid_q    <= 1'b0;
            outPc_q       <= 64'h0;
            outInstr_q    <= 32'h0;
            outMisalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            outValid_q    <= outValid_d;
            outPc_q       <= outPc_d;
            outInstr_q    <= outInstr_d;
            outMisalign_q <= outMisalign_d;
        end
    end

    assign out_valid    = outValid_q;
    assign out_pc       = outPc_q;
    assign out_instr    = outInstr_q;
    assign out_misalign = outMisalign_q;

endmodule

// File: tb/tb_pcfetch.sv
// tb_pcfetch: directed bench for pcfetch with a queue-based scoreboard.
// The stimulus process pushes the hand-computed instruction each scenario
// should deliver; a monitor process pops and compares whenever a new slot
// is presented to decode. A small bus responder answers requests after a
// programmable number of wait cycles with word {16'hC0DE, addr[15:0]}.
module tb_pcfetch;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    exp_t expQ[$];
    int   total;
    int   bad;
    int   seenCnt;
    int   busLat;

    pcfetch dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pushExp(input logic [63:0] pc, input logic [31:0] instr, input logic mis);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.mis   = mis;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic st);
        redirect_en = redir;
        redirect_pc = rpc;
        stall       = st;
    endtask

    task automatic applyReset(input logic useRedir, input logic [63:0] rpc);
        reset       = 1'b1;
        redirect_en = 1'b0;
        tick();
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_out_pc", out_pc, 64'h0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'h0);
        checkOutput("rst_out_misalign", 64'(out_misalign), 64'h0);
        checkOutput("rst_ireq_valid", 64'(ireq_valid), 64'h0);
        checkOutput("rst_queue_empty", 64'(expQ.size()), 64'h0);
        reset       = 1'b0;
        redirect_en = useRedir;
        redirect_pc = rpc;
        tick();
        redirect_en = 1'b0;
    endtask

    task automatic waitSeen(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (seenCnt >= target) return;
            tick();
        end
        if (seenCnt < target) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_delivery: got %0d deliveries expected %0d", seenCnt, target);
        end
    endtask

    // Bus responder: answers the outstanding request after busLat wait cycles.
    initial begin
        int cnt;
        cnt           = 0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        forever begin
            @(negedge clk);
            if (reset || !ireq_valid) begin
                iresp_data_ok = 1'b0;
                cnt           = 0;
            end else begin
                if (iresp_data_ok) cnt = 0;
                if (cnt >= busLat) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = {16'hC0DE, ireq_addr[15:0]};
                end else begin
                    iresp_data_ok = 1'b0;
                end
                cnt++;
            end
        end
    end

    // Monitor: pops an expectation for each newly presented slot and checks held slots stay put.
    initial begin
        logic        prevValid;
        logic        prevConsumed;
        logic [63:0] heldPc;
        logic [31:0] heldInstr;
        exp_t        e;
        prevValid    = 1'b0;
        prevConsumed = 1'b0;
        heldPc       = 64'h0;
        heldInstr    = 32'h0;
        seenCnt      = 0;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (!prevValid || prevConsumed) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_delivery: got pc %h expected none", out_pc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("deliver_pc", out_pc, e.pc);
                        checkOutput("deliver_instr", 64'(out_instr), 64'(e.instr));
                        checkOutput("deliver_misalign", 64'(out_misalign), 64'(e.mis));
                        heldPc    = e.pc;
                        heldInstr = e.instr;
                    end
                    seenCnt++;
                end else begin
                    checkOutput("held_pc", out_pc, heldPc);
                    checkOutput("held_instr", 64'(out_instr), 64'(heldInstr));
                end
            end
            #2;
            prevValid    = !reset && out_valid;
            prevConsumed = out_valid && (!stall || redirect_en);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int base;
        total  = 0;
        bad    = 0;
        busLat = 1;
        reset  = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0);

        // Sequential fetch from the reset PC with a one-wait-cycle bus.
        applyReset(1'b0, 64'h0);
        base = seenCnt;
        pushExp(64'h8000_0000, 32'hC0DE_0000, 1'b0);
        pushExp(64'h8000_0004, 32'hC0DE_0004, 1'b0);
        pushExp(64'h8000_0008, 32'hC0DE_0008, 1'b0);
        checkOutput("first_req_valid", 64'(ireq_valid), 64'h1);
        checkOutput("first_req_addr", ireq_addr, 64'h8000_0000);
        waitSeen(base + 3, 30);
        stall = 1'b1;

        // Stall holds the slot and keeps the bus idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_ireq_valid", 64'(ireq_valid), 64'h0);
            checkOutput("stall_out_valid", 64'(out_valid), 64'h1);
            checkOutput("stall_out_pc", out_pc, 64'h8000_0008);
            checkOutput("stall_out_instr", 64'(out_instr), 64'hC0DE_0008);
        end
        pushExp(64'h8000_000C, 32'hC0DE_000C, 1'b0);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checkOutput("consume_out_valid", 64'(out_valid), 64'h0);
        checkOutput("reissue_valid", 64'(ireq_valid), 64'h1);
        checkOutput("reissue_addr", ireq_addr, 64'h8000_000C);
        waitSeen(base + 4, 20);

        // Redirect while in IDLE right after reset.
        applyReset(1'b1, 64'h8000_4000);
        base = seenCnt;
        checkOutput("idle_redirect_addr", ireq_addr, 64'h8000_4000);
        pushExp(64'h8000_4000, 32'hC0DE_4000, 1'b0);
        waitSeen(base + 1, 20);

        // Redirect while the request waits: address stays put, old word dropped.
        busLat = 3;
        applyReset(1'b0, 64'h0);
        base = seenCnt;
        checkOutput("wait_first_addr", ireq_addr, 64'h8000_0000);
        applyStimulus(1'b1, 64'h8000_1000, 1'b1);
        tick();
        redirect_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ireq_addr == 64'h8000_1000) break;
            checkOutput("kill_addr_stable", ireq_addr, 64'h8000_0000);
            checkOutput("kill_ireq_valid", 64'(ireq_valid), 64'h1);
            checkOutput("kill_no_out", 64'(out_valid), 64'h0);
            tick();
        end
        checkOutput("kill_resume_addr", ireq_addr, 64'h8000_1000);
        pushExp(64'h8000_1000, 32'hC0DE_1000, 1'b0);
        waitSeen(base + 1, 20);

        // Two redirects while killing: latest target wins.
        busLat = 4;
        applyReset(1'b0, 64'h0);
        base = seenCnt;
        applyStimulus(1'b1, 64'h0000_0100, 1'b1);
        tick();
        applyStimulus(1'b1, 64'h0000_0200, 1'b1);
        tick();
        redirect_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ireq_addr != 64'h8000_0000) break;
            checkOutput("kill2_no_out", 64'(out_valid), 64'h0);
            tick();
        end
        checkOutput("kill2_resume_addr", ireq_addr, 64'h0000_0200);
        pushExp(64'h0000_0200, 32'hC0DE_0200, 1'b0);
        waitSeen(base + 1, 20);

        // Redirect in the same cycle as data_ok drops the word.
        busLat = 1;
        applyReset(1'b0, 64'h0);
        base = seenCnt;
        tick();
        applyStimulus(1'b1, 64'h8000_2000, 1'b1);
        tick();
        redirect_en = 1'b0;
        checkOutput("same_cycle_valid", 64'(ireq_valid), 64'h1);
        checkOutput("same_cycle_addr", ireq_addr, 64'h8000_2000);
        checkOutput("same_cycle_no_out", 64'(out_valid), 64'h0);
        pushExp(64'h8000_2000, 32'hC0DE_2000, 1'b0);
        waitSeen(base + 1, 20);

        // Redirect during a stalled HOLD flushes the slot next cycle.
        applyStimulus(1'b1, 64'h8000_3000, 1'b1);
        tick();
        redirect_en = 1'b0;
        checkOutput("hold_redirect_flush", 64'(out_valid), 64'h0);
        checkOutput("hold_redirect_addr", ireq_addr, 64'h8000_3000);
        pushExp(64'h8000_3000, 32'hC0DE_3000, 1'b0);
        waitSeen(base + 2, 20);

        // Misaligned redirect target.
        applyStimulus(1'b1, 64'h8000_0002, 1'b1);
        tick();
        redirect_en = 1'b0;
`ifdef PCFETCH_MISALIGN_EN
        checkOutput("misalign_no_req", 64'(ireq_valid), 64'h0);
        pushExp(64'h8000_0002, 32'h0, 1'b1);
        waitSeen(base + 3, 20);
        checkOutput("misalign_hold_no_req", 64'(ireq_valid), 64'h0);
        pushExp(64'h8000_0002, 32'h0, 1'b1);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checkOutput("misalign_retry_no_req", 64'(ireq_valid), 64'h0);
        waitSeen(base + 4, 20);
`else
        checkOutput("misalign_req_valid", 64'(ireq_valid), 64'h1);
        checkOutput("misalign_req_addr", ireq_addr, 64'h8000_0002);
        pushExp(64'h8000_0002, 32'hC0DE_0002, 1'b0);
        waitSeen(base + 3, 20);
        pushExp(64'h8000_0006, 32'hC0DE_0006, 1'b0);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checkOutput("misalign_next_addr", ireq_addr, 64'h8000_0006);
        waitSeen(base + 4, 20);
`endif

        tick();
        tick();
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
